// File: rtl/uart_tx_feeder_if.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_if
//
// Purpose: bundles the two handshakes of the UART transmit feeder.
//   - Bus-side byte write: wr_valid_i / wr_data_i / wr_ready_o
//   - Transmitter launch:  tx_data_o / tx_send_o / tx_ready_i / busy_i
// Signal suffixes are written from the feeder's point of view.
//
// Modports:
//   master : the environment (register write path + transmitter). It drives
//            the write request and the transmitter status.
//   slave  : the feeder itself. It drives wr_ready_o and the launch signals.
// ---------------------------------------------------------------------------
interface uart_tx_feeder_if;
  logic       wr_valid_i;
  logic [7:0] wr_data_i;
  logic       wr_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_send_o;
  logic       tx_ready_i;
  logic       busy_i;

  modport master (
    output wr_valid_i,
    output wr_data_i,
    input  wr_ready_o,
    input  tx_data_o,
    input  tx_send_o,
    output tx_ready_i,
    output busy_i
  );

  modport slave (
    input  wr_valid_i,
    input  wr_data_i,
    output wr_ready_o,
    output tx_data_o,
    output tx_send_o,
    input  tx_ready_i,
    input  busy_i
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//
// Purpose: byte FIFO plus launch FSM sitting between the register write path
// and the UART transmitter. Bytes written by the bus are buffered and handed
// to the transmitter one at a time with a one-cycle tx_send_o pulse, paced
// by the transmitter's tx_ready_i (drop = accepted, rise = ready again).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   tx_en_i      : launch enable; low holds bytes in the FIFO
//   fifo_clr_i   : flush FIFO contents (pulse); clear beats a same-cycle push
//   ovf_clr_i    : clear the sticky overflow flag (pulse); a same-cycle set wins
//   bus          : uart_tx_feeder_if.slave (write and launch handshakes)
//   count_o      : occupancy 0..DEPTH
//   empty_o      : count_o == 0
//   full_o       : count_o == DEPTH
//   overflow_o   : sticky, a write was attempted while full
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_en_i,
  input  logic            fifo_clr_i,
  input  logic            ovf_clr_i,
  uart_tx_feeder_if.slave bus,
  output logic [AW:0]     count_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            overflow_o
);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_feeder: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_RDY = 2'd3
  } state_t;

  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [7:0]    tx_data;
  logic          overflow;

  logic          push;
  logic          launch;
  logic          empty;
  logic          full;

  // The transmitter busy flag is reported elsewhere as status only; the
  // launch sequencing relies purely on tx_ready_i.
  logic          unused_busy;
  assign unused_busy = bus.busy_i;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // wr_ready_o deliberately ignores a same-cycle pop: a full FIFO refuses
  // the write even on the edge that frees an entry.
  assign push   = bus.wr_valid_i && !full && !fifo_clr_i;

  // A launch is the only way a byte leaves the FIFO.
  assign launch = (state == IDLE) && tx_en_i && !empty && bus.tx_ready_i;

  // -------------------------------------------------------------------------
  // Launch FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Launch FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Transmitter signals acceptance by dropping ready.
        if (!bus.tx_ready_i) begin
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.tx_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO storage (data only, no reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.wr_data_i;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || fifo_clr_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (launch) begin
        rptr <= rptr + PTR_ONE;
      end
      unique case ({push, launch})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Launch data register: loaded only on the launch edge, so the byte stays
  // stable until the next launch. A flush leaves the in-flight byte alone.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= 8'h00;
    end else if (launch) begin
      tx_data <= mem[rptr];
    end
  end

  // -------------------------------------------------------------------------
  // Sticky overflow: set has priority over clear
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (bus.wr_valid_i && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr_i) begin
      overflow <= 1'b0;
    end
  end

  assign bus.wr_ready_o = !full;
  assign bus.tx_data_o  = tx_data;
  assign bus.tx_send_o  = (state == SEND);
  assign count_o        = count;
  assign empty_o        = empty;
  assign full_o         = full;
  assign overflow_o     = overflow;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
//
// Self-checking bench for uart_tx_feeder. A queue-based model of the FIFO
// and the launch handshake predicts every output each cycle; directed
// scenarios add literal expectations and an order/loss scoreboard.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_en = 1'b0;
  logic          fifo_clr = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;

  uart_tx_feeder_if bus ();

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en_i    (tx_en),
    .fifo_clr_i (fifo_clr),
    .ovf_clr_i  (ovf_clr),
    .bus        (bus),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (updated on each active edge) ----------
  logic [7:0] mq[$];         // bytes queued, oldest first
  bit         m_ovf;
  logic [7:0] m_data;
  bit         m_send;        // a launch happened on the last edge
  bit         hs_open;       // a launched byte's handshake is still running
  bit         hs_acked;      // transmitter has dropped ready for it
  bit         model_live = 0;

  always @(posedge clk) begin : model
    bit was_full;
    bit launch;
    if (rst) begin
      mq.delete();
      m_ovf    = 0;
      m_data   = 8'h00;
      m_send   = 0;
      hs_open  = 0;
      hs_acked = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      launch   = !hs_open && tx_en && (mq.size() > 0) && bus.tx_ready_i;
      // The send cycle itself does not look at ready; afterwards a drop then a rise.
      if (hs_open && !m_send) begin
        if (!hs_acked) begin
          if (!bus.tx_ready_i) hs_acked = 1;
        end else if (bus.tx_ready_i) begin
          hs_open = 0;
        end
      end
      m_send = launch;
      if (launch) begin
        m_data   = mq.pop_front();
        hs_open  = 1;
        hs_acked = 0;
      end
      if (bus.wr_valid_i && was_full) m_ovf = 1;
      else if (ovf_clr)               m_ovf = 0;
      if (fifo_clr)                         mq.delete();
      else if (bus.wr_valid_i && !was_full) mq.push_back(bus.wr_data_i);
    end
    model_live = 1;
  end

  // ---------------- per-cycle compare and launch log -----------------------
  int         n_sends = 0;
  logic [7:0] sent_log[$];
  bit         prev_send = 0;

  always @(negedge clk) begin
    if (model_live) begin
      chk("count",      32'(count),           32'(mq.size()));
      chk("empty",      32'(empty),           32'(mq.size() == 0));
      chk("full",       32'(full),            32'(mq.size() == DEPTH));
      chk("wr_ready",   32'(bus.wr_ready_o),  32'(mq.size() != DEPTH));
      chk("overflow",   32'(overflow),        32'(m_ovf));
      chk("tx_send",    32'(bus.tx_send_o),   32'(m_send));
      chk("tx_data",    32'(bus.tx_data_o),   32'(m_data));
      chk("send_gap",   32'(prev_send & bus.tx_send_o), 32'd0);
      if (bus.tx_send_o === 1'b1) begin
        n_sends++;
        sent_log.push_back(bus.tx_data_o);
      end
      prev_send = (bus.tx_send_o === 1'b1);
    end
  end

  // ---------------- transmitter model --------------------------------------
  // Drops ready the cycle after a send pulse, raises it again later.
  bit rand_delay = 0;

  initial begin : xmit
    int  hold;
    bit  saw_send;
    hold     = 0;
    saw_send = 0;
    bus.tx_ready_i = 1'b1;
    bus.busy_i     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (saw_send) begin
        bus.tx_ready_i = 1'b0;
        hold = rand_delay ? int'($urandom_range(0, 6)) : 19;
      end else if (!bus.tx_ready_i) begin
        if (hold == 0) bus.tx_ready_i = 1'b1;
        else           hold--;
      end
      saw_send   = (bus.tx_send_o === 1'b1);
      bus.busy_i = !bus.tx_ready_i;
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = b;
    step();
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    tx_en  = 1'b1;
    while (!(mq.size() == 0 && !hs_open && bus.tx_ready_i) && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_timeout", 32'(budget == 0), 32'd0);
  endtask

  task automatic wait_send();
    int budget;
    budget = 200;
    while (bus.tx_send_o !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    chk("send_timeout", 32'(budget == 0), 32'd0);
  endtask

  // ---------------- scenarios ----------------------------------------------
  initial begin : main
    int         s0;
    logic [7:0] list[$];
    logic [7:0] b;
    logic [7:0] first;
    int         pushed;
    int         budget;

    bus.wr_valid_i = 1'b0;
    bus.wr_data_i  = 8'h00;
    step(3);

    // Reset values, pinned literally
    chk("rst_count",    32'(count),          32'd0);
    chk("rst_empty",    32'(empty),          32'd1);
    chk("rst_full",     32'(full),           32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready_o), 32'd1);
    chk("rst_send",     32'(bus.tx_send_o),  32'd0);
    chk("rst_data",     32'(bus.tx_data_o),  32'h00);
    chk("rst_ovf",      32'(overflow),       32'd0);
    rst = 1'b0;
    step();

    // 1. Single byte, launch one edge after the write
    tx_en = 1'b1;
    s0 = n_sends;
    push(8'hA5);
    chk("t1_count_after_push", 32'(count),         32'd1);
    chk("t1_no_send_yet",      32'(bus.tx_send_o), 32'd0);
    step();
    chk("t1_send",             32'(bus.tx_send_o), 32'd1);
    chk("t1_data",             32'(bus.tx_data_o), 32'hA5);
    chk("t1_count_zero",       32'(count),         32'd0);
    step();
    chk("t1_send_single",      32'(bus.tx_send_o), 32'd0);
    drain();
    chk("t1_pulses",           32'(n_sends - s0),  32'd1);

    // 2. Burst ordering with a full FIFO
    tx_en = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    chk("t2_full",     32'(full),           32'd1);
    chk("t2_count",    32'(count),          32'd16);
    chk("t2_wr_ready", 32'(bus.wr_ready_o), 32'd0);
    sent_log.delete();
    s0 = n_sends;
    drain();
    chk("t2_pulses",   32'(n_sends - s0),   32'd16);
    chk("t2_log_size", 32'(sent_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent_log.size(); i++)
      chk("t2_order", 32'(sent_log[i]), 32'(i + 1));
    chk("t2_empty",    32'(empty),          32'd1);

    // 3. Overflow set / hold / clear, and set beating clear
    tx_en = 1'b0;
    for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
    chk("t3_ovf_set",  32'(overflow), 32'd1);
    chk("t3_count",    32'(count),    32'd16);
    step(5);
    chk("t3_ovf_hold", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr",  32'(overflow), 32'd0);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 8'h77;
    ovf_clr        = 1'b1;
    step();
    bus.wr_valid_i = 1'b0;
    ovf_clr        = 1'b0;
    chk("t3_set_wins", 32'(overflow), 32'd1);
    fifo_clr = 1'b1;
    ovf_clr  = 1'b1;
    step();
    fifo_clr = 1'b0;
    ovf_clr  = 1'b0;
    chk("t3_flushed",  32'(count),    32'd0);

    // 4. Wrap with concurrent push and pop, 40 bytes
    rand_delay = 1;
    list.delete();
    sent_log.delete();
    tx_en  = 1'b0;
    pushed = 0;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      list.push_back(b);
      push(b);
      pushed++;
    end
    tx_en  = 1'b1;
    budget = 2000;
    while (pushed < 40 && budget > 0) begin
      // Push whenever a launch is due on the next edge, occasionally otherwise.
      if ((!hs_open && bus.tx_ready_i && mq.size() > 0) ||
          ($urandom_range(0, 7) == 0 && mq.size() < 12)) begin
        b = 8'($urandom);
        list.push_back(b);
        pushed++;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = b;
      end
      step();
      bus.wr_valid_i = 1'b0;
      budget--;
    end
    chk("t4_push_timeout", 32'(budget == 0), 32'd0);
    drain();
    chk("t4_count_sent", 32'(sent_log.size()), 32'(list.size()));
    for (int i = 0; i < list.size() && i < sent_log.size(); i++)
      chk("t4_scoreboard", 32'(sent_log[i]), 32'(list[i]));

    // 5. Flush while a launch is in flight
    rand_delay = 0;
    tx_en = 1'b0;
    list.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      list.push_back(b);
      push(b);
    end
    first = list[0];
    tx_en = 1'b1;
    wait_send();
    chk("t5_first", 32'(bus.tx_data_o), 32'(first));
    step();
    fifo_clr       = 1'b1;
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 8'hEE;
    step();
    fifo_clr       = 1'b0;
    bus.wr_valid_i = 1'b0;
    chk("t5_count",   32'(count),         32'd0);
    chk("t5_data",    32'(bus.tx_data_o), 32'(first));
    s0 = n_sends;
    step(60);
    chk("t5_no_send", 32'(n_sends - s0),  32'd0);
    chk("t5_data2",   32'(bus.tx_data_o), 32'(first));
    drain();

    // 6. Reset during the acknowledge wait with 3 bytes queued
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    tx_en = 1'b1;
    wait_send();
    step();
    chk("t6_queued", 32'(count), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_count",    32'(count),          32'd0);
    chk("t6_empty",    32'(empty),          32'd1);
    chk("t6_full",     32'(full),           32'd0);
    chk("t6_wr_ready", 32'(bus.wr_ready_o), 32'd1);
    chk("t6_send",     32'(bus.tx_send_o),  32'd0);
    chk("t6_data",     32'(bus.tx_data_o),  32'h00);
    chk("t6_ovf",      32'(overflow),       32'd0);
    s0 = n_sends;
    step(40);
    chk("t6_no_send",  32'(n_sends - s0),   32'd0);
    push(8'h5A);
    wait_send();
    chk("t6_new_data", 32'(bus.tx_data_o),  32'h5A);
    drain();

    // 7. Random mix of all controls, checked by the per-cycle model
    rand_delay = 1;
    for (int c = 0; c < 800; c++) begin
      tx_en          = ($urandom_range(0, 3) != 0);
      bus.wr_valid_i = ($urandom_range(0, 2) == 0);
      bus.wr_data_i  = 8'($urandom);
      fifo_clr       = ($urandom_range(0, 60) == 0);
      ovf_clr        = ($urandom_range(0, 20) == 0);
      step();
    end
    bus.wr_valid_i = 1'b0;
    fifo_clr       = 1'b0;
    ovf_clr        = 1'b0;
    drain();
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
